// File: rtl/inst_cache_pkg.sv
// ============================================================
// Package  : inst_cache_pkg
// Purpose  : shared state encoding, constants and address helpers
// Revision : 1.0
// ============================================================
`default_nettype none

package inst_cache_pkg;

  localparam int DEF_INDEX_BITS    = 5;
  localparam int DEF_WORD_OFF_BITS = 2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic HIGH  = 1'b1;
  localparam logic LOW   = 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // First byte address of the line holding pc.
  function automatic logic [31:0] line_base(input logic [31:0] pc, input int word_off_bits);
    return (pc >> (word_off_bits + 2)) << (word_off_bits + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_cache_if.sv
// ============================================================
// Interface : inst_cache_if
// Purpose   : fetch-side request/response and memory-side fill bus
// Revision  : 1.0
// ============================================================
`default_nettype none

interface inst_cache_if;

  logic        pc_send_enable;
  logic [31:0] pc_to_ic;
  logic        jump_flag;
  logic        inst_get_ready;
  logic [31:0] inst_from_ic;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  modport slave (
    input  pc_send_enable, pc_to_ic, jump_flag, mem_valid, mem_data,
    output inst_get_ready, inst_from_ic, mem_req, mem_addr
  );

  modport master (
    output pc_send_enable, pc_to_ic, jump_flag, mem_valid, mem_data,
    input  inst_get_ready, inst_from_ic, mem_req, mem_addr
  );

endinterface

`default_nettype wire

// File: rtl/inst_cache_array.sv
// ============================================================
// Module   : icache_array
// Purpose  : tag/valid/data storage, combinational read, sync write
// Revision : 1.0
// ============================================================
`default_nettype none

module icache_array #(
  parameter int INDEX_BITS    = 5,
  parameter int WORD_OFF_BITS = 2,
  parameter int TAG_BITS      = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INDEX_BITS-1:0]    rd_index,
  input  logic [WORD_OFF_BITS-1:0] rd_word,
  output logic                     rd_valid,
  output logic [TAG_BITS-1:0]      rd_tag,
  output logic [31:0]              rd_data,
  input  logic                     wr_en,
  input  logic                     wr_last,
  input  logic [INDEX_BITS-1:0]    wr_index,
  input  logic [WORD_OFF_BITS-1:0] wr_word,
  input  logic [31:0]              wr_data,
  input  logic [TAG_BITS-1:0]      wr_tag
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << WORD_OFF_BITS;

  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    valid_d;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES*WORDS];

  always_comb begin
    valid_d = valid_q;
    if (wr_en && wr_last) begin
      valid_d[wr_index] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data contents are don't-care until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_index, wr_word}] <= wr_data;
      if (wr_last) begin
        tag_mem[wr_index] <= wr_tag;
      end
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_word}];

endmodule

`default_nettype wire

// File: rtl/inst_cache.sv
// ============================================================
// Module   : inst_cache
// Purpose  : direct-mapped read-only instruction cache; optional
//            early restart enabled by ICACHE_EARLY_RESTART_EN
// Revision : 1.0
// ============================================================
`default_nettype none

module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS    = DEF_INDEX_BITS,
  parameter int WORD_OFF_BITS = DEF_WORD_OFF_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  inst_cache_if.slave  bus
);

  localparam int TAG_BITS = 32 - 2 - WORD_OFF_BITS - INDEX_BITS;
  localparam int IDX_LSB  = WORD_OFF_BITS + 2;
  localparam int TAG_LSB  = 32 - TAG_BITS;
  localparam logic [WORD_OFF_BITS-1:0] LAST_WORD = '1;

  state_e                   state_q, state_d;
  logic                     igr_q, igr_d;
  logic [31:0]              ifi_q, ifi_d;
  logic                     mem_req_q, mem_req_d;
  logic [31:0]              mem_addr_q, mem_addr_d;
  logic [WORD_OFF_BITS-1:0] cnt_q, cnt_d;
  logic [WORD_OFF_BITS-1:0] cnt_inc;

`ifdef ICACHE_EARLY_RESTART_EN
  logic                     served_q, served_d;
  logic [WORD_OFF_BITS-1:0] req_word_q, req_word_d;
`endif

  logic [INDEX_BITS-1:0]    rd_index;
  logic [WORD_OFF_BITS-1:0] rd_word;
  logic [TAG_BITS-1:0]      req_tag;
  logic                     rd_valid;
  logic [TAG_BITS-1:0]      rd_tag;
  logic [31:0]              rd_data;
  logic                     hit;
  logic                     lookup_ok;
  logic                     wr_en;
  logic                     wr_last;
  logic                     unused_pc_bits;

  assign rd_index       = bus.pc_to_ic[IDX_LSB +: INDEX_BITS];
  assign rd_word        = bus.pc_to_ic[2 +: WORD_OFF_BITS];
  assign req_tag        = bus.pc_to_ic[TAG_LSB +: TAG_BITS];
  assign unused_pc_bits = ^bus.pc_to_ic[1:0];
  assign hit            = rd_valid && (rd_tag == req_tag);
  assign cnt_inc        = cnt_q + 1'b1;

  icache_array #(
    .INDEX_BITS   (INDEX_BITS),
    .WORD_OFF_BITS(WORD_OFF_BITS),
    .TAG_BITS     (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (rd_index),
    .rd_word  (rd_word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_last  (wr_last),
    .wr_index (mem_addr_q[IDX_LSB +: INDEX_BITS]),
    .wr_word  (cnt_q),
    .wr_data  (bus.mem_data),
    .wr_tag   (mem_addr_q[TAG_LSB +: TAG_BITS])
  );

  always_comb begin
    state_d    = state_q;
    igr_d      = LOW;
    ifi_d      = ifi_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    cnt_d      = cnt_q;
    wr_en      = FALSE;
    wr_last    = FALSE;
    // A pulse in flight blocks lookup so a held request yields one response.
    lookup_ok  = bus.pc_send_enable && !bus.jump_flag && !igr_q;
`ifdef ICACHE_EARLY_RESTART_EN
    served_d   = served_q;
    req_word_d = req_word_q;
    lookup_ok  = lookup_ok && !served_q;
`endif
    if (rdy) begin
      case (state_q)
        ST_IDLE: begin
`ifdef ICACHE_EARLY_RESTART_EN
          served_d = FALSE;
`endif
          if (lookup_ok) begin
            if (hit) begin
              igr_d = HIGH;
              ifi_d = rd_data;
            end else begin
              state_d    = ST_FILL;
              mem_req_d  = HIGH;
              mem_addr_d = line_base(bus.pc_to_ic, WORD_OFF_BITS);
              cnt_d      = '0;
`ifdef ICACHE_EARLY_RESTART_EN
              req_word_d = rd_word;
`endif
            end
          end
        end
        ST_FILL: begin
          if (bus.mem_valid) begin
            wr_en = TRUE;
            if (cnt_q == LAST_WORD) begin
              wr_last   = TRUE;
              mem_req_d = LOW;
              state_d   = ST_IDLE;
            end else begin
              cnt_d      = cnt_inc;
              mem_addr_d = {mem_addr_q[31:IDX_LSB], cnt_inc, 2'b00};
            end
`ifdef ICACHE_EARLY_RESTART_EN
            if (!served_q && (cnt_q == req_word_q) && bus.pc_send_enable && !bus.jump_flag) begin
              igr_d    = HIGH;
              ifi_d    = bus.mem_data;
              served_d = TRUE;
            end
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      igr_q      <= LOW;
      ifi_q      <= '0;
      mem_req_q  <= LOW;
      mem_addr_q <= '0;
      cnt_q      <= '0;
`ifdef ICACHE_EARLY_RESTART_EN
      served_q   <= FALSE;
      req_word_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      igr_q      <= igr_d;
      ifi_q      <= ifi_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
`ifdef ICACHE_EARLY_RESTART_EN
      served_q   <= served_d;
      req_word_q <= req_word_d;
`endif
    end
  end

  assign bus.inst_get_ready = igr_q;
  assign bus.inst_from_ic   = ifi_q;
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_addr       = mem_addr_q;

endmodule

`default_nettype wire

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache between the memory controller (upstream) and the instruction-fetch stage (downstream).
- Accepts a PC request from fetch and returns the 32-bit instruction on a hit.
- On a miss, fills the whole line word-by-word from the memory controller, then re-looks-up.
- Holds no dirty state; fence or invalidation is not supported.

Parameters:
- INDEX_BITS, 5, log2 of line count (32 lines).
- WORD_OFF_BITS, 2, log2 of words per line (4 words = 16 B).
- TAG_BITS, 32-2-WORD_OFF_BITS-INDEX_BITS, derived; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global ready; low = freeze.
- pc_send_enable  input  1  fetch request valid; level, held by fetch until served.
- pc_to_ic  input  32  request PC, word-aligned (bits[1:0] ignored).
- jump_flag  input  1  redirect; cancels any pending response.
- inst_get_ready  output  1  one-cycle pulse: inst_from_ic valid.
- inst_from_ic  output  32  instruction word.
- mem_req  output  1  word-read request to memory controller, level.
- mem_addr  output  32  word address of the request.
- mem_valid  input  1  one-cycle: mem_data holds the word for the current mem_addr.
- mem_data  input  32  returned word.

Behaviour:
- Address split:
  - word_off = pc[WORD_OFF_BITS+1:2]
  - index = next INDEX_BITS bits
  - tag = remaining upper bits
- Reset (rst=0, async):
  - all valid bits cleared; state=IDLE
  - inst_get_ready=0, inst_from_ic=0, mem_req=0, mem_addr=0, fill counter=0
  - tag/data arrays are not reset.
- States: IDLE, FILL.
- IDLE:
  - If pc_send_enable=1 and inst_get_ready=0:
    - hit (valid[index] and tag match) → next edge inst_get_ready=1, inst_from_ic=data[index][word_off]; latency 1 cycle.
    - miss → latch line base address, counter=0, mem_req=1, mem_addr=base, go FILL.
  - inst_get_ready is forced low the cycle after a pulse, so one request yields exactly one pulse even if fetch keeps enable high one extra cycle.
- FILL:
  - On mem_valid:
    - write data[index][counter] = mem_data
    - if counter = last: mem_req=0, valid[index]=1, tag stored, go IDLE
    - else: counter+1, mem_addr+=4, mem_req stays 1
  - Miss penalty = 4 memory transactions + 1 relookup cycle + 1 response cycle.
- jump_flag=1:
  - Clears any pending inst_get_ready next edge.
  - IDLE lookup in the same cycle is suppressed.
  - An in-progress FILL always completes (the memory controller is not aborted); the line becomes valid; no response is issued.
- rdy=0:
  - All state, counters and arrays hold.
  - inst_get_ready is driven 0; mem_req keeps its value.
  - mem_valid arriving while rdy=0 is ignored; the controller must hold or retry.
- Simultaneous pc_send_enable and mem_valid in FILL: only the fill is processed; the request is served after return to IDLE.
- Line index wraps naturally; mem_addr increments within the line only (no carry into index).

Optional Feature:
- Macro ICACHE_EARLY_RESTART_EN.
- Defined: during FILL, if mem_valid's word matches the latched request word_off, pc_send_enable=1 and jump_flag=0, then next edge inst_get_ready=1 and inst_from_ic=mem_data.
  - The request is marked served; the relookup after fill does not pulse again unless a new request arrives.
  - Miss latency becomes (word_off+1) transactions + 1 cycle.
- Undefined: no forwarding; response only via IDLE hit.

Decomposition:
- Shared package (config include):
  - state encoding IDLE/FILL
  - TRUE/FALSE/HIGH/LOW constants
  - INDEX_BITS/WORD_OFF_BITS defaults
  - address field helper macros
- One sub-module: icache_array.
  - Tag + valid + data storage.
  - Combinational read by index/word_off, synchronous write port.
  - Valid clear on reset.
- The FSM and handshake logic stay in inst_cache.

Test Plan:
- Reset, then request pc=0x0000_0000 → mem_req=1 with mem_addr 0x0, 0x4, 0x8, 0xC; respond 0x11,0x22,0x33,0x44 → inst_get_ready pulses once with 0x11.
- Then request pc=0x0000_0008 → pulse next cycle with 0x33, no mem_req.
- Conflict: pc=0x0000_0200 (same index, new tag) → refill; then pc=0x0 → miss again.
- jump_flag asserted mid-FILL → fill completes, line valid, no inst_get_ready. A later request for that line hits in 1 cycle.
- rdy=0 for 3 cycles during FILL with mem_valid withheld → counter, mem_addr, mem_req unchanged. Fill resumes correctly after rdy=1.
- With ICACHE_EARLY_RESTART_EN, miss on pc=0x4 → pulse with word 1 the cycle after its mem_valid. No second pulse after fill.
